// File: rtl/seq_alu_if.sv
// seq_alu_if: request/result bundle between an ALU client and seq_alu.
// master drives the request and flag restore; slave returns ready, result and flags.
// ccr bit order is {V,C,N,Z}.
interface seq_alu_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [4:0]       sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flag_ld;
  logic [3:0]       flag_in;
  logic             ready;
  logic             valid_out;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_hi;
  logic [3:0]       ccr;

  modport master (
    output start, sel, a, b, flag_ld, flag_in,
    input  ready, valid_out, out, out_hi, ccr
  );

  modport slave (
    input  start, sel, a, b, flag_ld, flag_in,
    output ready, valid_out, out, out_hi, ccr
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle ops and iterative MUL/DIVU.
// Latency: 1 cycle for ops 0x01-0x0F, WIDTH+1 cycles for MUL/DIVU.
// Backpressure: ready=0 while MUL/DIVU iterate; start is dropped (not queued) then.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input logic    clk,
  input logic    rst,
  seq_alu_if.slave bus
);
  localparam logic [4:0] OP_NOP = 5'h00, OP_PASSB = 5'h01, OP_ADD = 5'h02, OP_SUB = 5'h03,
                         OP_AND = 5'h04, OP_OR = 5'h05, OP_RLC = 5'h06, OP_RRC = 5'h07,
                         OP_NOT = 5'h08, OP_NEG = 5'h09, OP_INC = 5'h0A, OP_DEC = 5'h0B,
                         OP_SETC = 5'h0C, OP_CLRC = 5'h0D, OP_PASSA = 5'h0E, OP_INCA = 5'h0F,
                         OP_MUL = 5'h10, OP_DIVU = 5'h11;
  localparam int M = WIDTH - 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_div;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
  logic [WIDTH-1:0] r_out, r_out_hi;
  logic [3:0]       r_ccr;
  logic             r_vld;

  logic             w_accept, w_multi;
  logic [WIDTH:0]   w_add, w_sub;
  logic [WIDTH-1:0] w_res;
  logic [3:0]       w_flg, w_mask;
  logic             w_vld;
  logic [WIDTH:0]   w_msum, w_dshift;
  logic [WIDTH-1:0] w_ddiff;
  logic             w_dge;

  assign w_accept = bus.start && (r_state == S_IDLE);
  assign w_multi  = (bus.sel == OP_MUL) || (bus.sel == OP_DIVU);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state: enter BUSY on MUL/DIVU acceptance, leave once the counter has drained
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_multi) w_next = S_BUSY;
      S_BUSY: if (r_cnt == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Single-cycle result, candidate flags {V,C,N,Z} and the mask of flags the op owns
  always_comb begin
    w_add  = {1'b0, bus.a} + {1'b0, bus.b};
    w_sub  = {1'b0, bus.a} - {1'b0, bus.b};
    w_res  = r_out;
    w_flg  = r_ccr;
    w_mask = 4'b0000;
    w_vld  = 1'b1;
    case (bus.sel)
      OP_PASSB: w_res = bus.b;
      OP_ADD: begin
        w_res = w_add[M:0]; w_mask = 4'b1111; w_flg[2] = w_add[WIDTH];
        w_flg[3] = (bus.a[M] == bus.b[M]) && (w_add[M] != bus.a[M]);
      end
      OP_SUB: begin
        w_res = w_sub[M:0]; w_mask = 4'b1111; w_flg[2] = w_sub[WIDTH];
        w_flg[3] = (bus.a[M] != bus.b[M]) && (w_sub[M] != bus.a[M]);
      end
      OP_AND: begin w_res = bus.a & bus.b; w_mask = 4'b0011; end
      OP_OR:  begin w_res = bus.a | bus.b; w_mask = 4'b0011; end
      OP_RLC: begin w_res = {bus.b[M-1:0], r_ccr[2]}; w_flg[2] = bus.b[M]; w_mask = 4'b0100; end
      OP_RRC: begin w_res = {r_ccr[2], bus.b[M:1]};   w_flg[2] = bus.b[0]; w_mask = 4'b0100; end
      OP_NOT: begin w_res = ~bus.b; w_mask = 4'b0011; end
      OP_NEG: begin w_res = -bus.b; w_mask = 4'b0011; end
      OP_INC: begin
        w_res = bus.b + 1'b1; w_mask = 4'b1111;
        w_flg[3] = (bus.b == {1'b0, {M{1'b1}}});
        w_flg[2] = (bus.b == {WIDTH{1'b1}});
      end
      OP_DEC: begin
        w_res = bus.b - 1'b1; w_mask = 4'b1111;
        w_flg[3] = (bus.b == {1'b1, {M{1'b0}}});
        w_flg[2] = (bus.b == '0);
      end
      OP_SETC:  begin w_flg[2] = 1'b1; w_mask = 4'b0100; end
      OP_CLRC:  begin w_flg[2] = 1'b0; w_mask = 4'b0100; end
      OP_PASSA: w_res = bus.a;
      OP_INCA:  w_res = bus.a + 1'b1;
      default:  w_vld = 1'b0;
    endcase
    w_flg[1] = w_res[M];
    w_flg[0] = (w_res == '0);
  end

  // One multiply step (shift-add) and one divide step (restoring subtract)
  always_comb begin
    w_msum   = {1'b0, r_hi} + ({(WIDTH+1){r_lo[0]}} & {1'b0, r_b});
    w_dshift = {r_hi, r_lo[M]};
    w_dge    = (w_dshift >= {1'b0, r_b});
    w_ddiff  = w_dshift[M:0] - r_b;
  end

  // Datapath: operand capture, iteration, result/flag registers and the valid pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0; r_div <= 1'b0; r_a <= '0; r_b <= '0; r_hi <= '0; r_lo <= '0;
      r_out <= '0; r_out_hi <= '0; r_ccr <= 4'b0000; r_vld <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (w_accept && w_multi) begin
        r_div <= (bus.sel == OP_DIVU);
        r_a   <= bus.a;
        r_b   <= bus.b;
        r_hi  <= '0;
        r_lo  <= bus.a;
        r_cnt <= CNT_W'(WIDTH);
      end else if (w_accept) begin
        r_out <= w_res;
        r_ccr <= (r_ccr & ~w_mask) | (w_flg & w_mask);
        r_vld <= w_vld;
      end else if (r_state == S_BUSY && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
        if (r_div) begin
          r_hi <= w_dge ? w_ddiff : w_dshift[M:0];
          r_lo <= {r_lo[M-1:0], w_dge};
        end else begin
          r_hi <= w_msum[WIDTH:1];
          r_lo <= {w_msum[0], r_lo[M:1]};
        end
      end else if (r_state == S_BUSY) begin
        r_vld <= 1'b1;
        if (r_div) begin
          // Divide by zero returns all ones and the dividend, flagged by V
          r_out    <= (r_b == '0) ? {WIDTH{1'b1}} : r_lo;
          r_out_hi <= (r_b == '0) ? r_a : r_hi;
          r_ccr    <= {(r_b == '0), 1'b0,
                       (r_b == '0) ? 1'b1 : r_lo[M],
                       (r_b == '0) ? 1'b0 : (r_lo == '0)};
        end else begin
          r_out    <= r_lo;
          r_out_hi <= r_hi;
          r_ccr    <= {(r_hi != '0), (r_hi != '0), r_hi[M], ({r_hi, r_lo} == '0)};
        end
      end
      // Flag restore takes priority over any result-driven update
      if (bus.flag_ld) r_ccr <= bus.flag_in;
    end
  end

  assign bus.ready     = (r_state == S_IDLE);
  assign bus.valid_out = r_vld;
  assign bus.out       = r_out;
  assign bus.out_hi    = r_out_hi;
  assign bus.ccr       = r_ccr;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors with hand-computed results for seq_alu at WIDTH=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Multi-cycle ops are waited on with a fixed cycle budget.
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  seq_alu_if #(.WIDTH(8)) bus ();
  seq_alu #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request for one cycle; returns at the sample point after the acceptance edge
  task automatic apply(input logic [4:0] s, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    bus.start = 1'b1; bus.sel = s; bus.a = x; bus.b = y;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Run MUL/DIVU, optionally poke start mid-flight, then check latency and result
  task automatic run_multi(input string tag, input logic [4:0] s, input logic [7:0] x,
                           input logic [7:0] y, input logic [7:0] e_out,
                           input logic [7:0] e_hi, input logic [3:0] e_ccr, input bit poke);
    int  lat;
    bit  busy_ok;
    lat = 0;
    busy_ok = 1'b1;
    apply(s, x, y);
    for (int k = 1; k <= 20; k++) begin
      if (poke && k == 3) begin bus.start = 1'b1; bus.sel = 5'h02; bus.a = 8'h33; bus.b = 8'h44; end
      if (poke && k == 4) bus.start = 1'b0;
      @(negedge clk);
      if (k <= 8 && (bus.ready !== 1'b0 || bus.valid_out !== 1'b0)) busy_ok = 1'b0;
      if (bus.valid_out === 1'b1) begin lat = k; break; end
    end
    bus.start = 1'b0;
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_lat"}, lat, 9);
    check({tag, "_out"}, bus.out, e_out);
    check({tag, "_hi"}, bus.out_hi, e_hi);
    check({tag, "_ccr"}, bus.ccr, e_ccr);
  endtask

  initial begin
    bit quiet;
    bus.start = 1'b0; bus.sel = 5'h00; bus.a = 8'h00; bus.b = 8'h00;
    bus.flag_ld = 1'b0; bus.flag_in = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.ready, 1);
    check("rst_valid", bus.valid_out, 0);
    check("rst_out", bus.out, 8'h00);
    check("rst_hi", bus.out_hi, 8'h00);
    check("rst_ccr", bus.ccr, 4'b0000);
    rst = 1'b0;

    apply(5'h02, 8'h7F, 8'h01);
    check("add_out", bus.out, 8'h80);
    check("add_vld", bus.valid_out, 1);
    check("add_ccr", bus.ccr, 4'b1010);
    @(negedge clk);
    check("vld_pulse", bus.valid_out, 0);

    apply(5'h0C, 8'h00, 8'h00);
    check("setc_ccr", bus.ccr, 4'b1110);
    check("setc_out", bus.out, 8'h80);
    apply(5'h06, 8'h00, 8'h80);
    check("rlc_out", bus.out, 8'h01);
    check("rlc_ccr", bus.ccr, 4'b1110);
    apply(5'h07, 8'h00, 8'h00);
    check("rrc_out", bus.out, 8'h80);
    check("rrc_ccr", bus.ccr, 4'b1010);

    apply(5'h03, 8'h00, 8'h01);
    check("sub_out", bus.out, 8'hFF);
    check("sub_ccr", bus.ccr, 4'b0110);
    apply(5'h04, 8'hF0, 8'h0F);
    check("and_out", bus.out, 8'h00);
    check("and_ccr", bus.ccr, 4'b0101);
    apply(5'h0A, 8'h00, 8'h7F);
    check("inc_out", bus.out, 8'h80);
    check("inc_ccr", bus.ccr, 4'b1010);
    apply(5'h0B, 8'h00, 8'h00);
    check("dec_out", bus.out, 8'hFF);
    check("dec_ccr", bus.ccr, 4'b0110);
    apply(5'h09, 8'h00, 8'h01);
    check("neg_out", bus.out, 8'hFF);
    check("neg_ccr", bus.ccr, 4'b0110);
    apply(5'h0E, 8'h5A, 8'h00);
    check("passa_out", bus.out, 8'h5A);
    apply(5'h0F, 8'hFF, 8'h00);
    check("inca_out", bus.out, 8'h00);
    check("inca_ccr", bus.ccr, 4'b0110);
    apply(5'h00, 8'h12, 8'h34);
    check("nop_vld", bus.valid_out, 0);
    check("nop_out", bus.out, 8'h00);

    run_multi("mul16", 5'h10, 8'h10, 8'h10, 8'h00, 8'h01, 4'b1100, 1'b1);
    run_multi("mulff", 5'h10, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b1110, 1'b0);
    run_multi("div7", 5'h11, 8'd100, 8'd7, 8'h0E, 8'h02, 4'b0000, 1'b0);
    run_multi("div0", 5'h11, 8'd7, 8'd0, 8'hFF, 8'h07, 4'b1010, 1'b0);

    // Abort a MUL with reset in its fourth cycle
    apply(5'h10, 8'h10, 8'h10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", bus.ready, 1);
    check("abort_ccr", bus.ccr, 4'b0000);
    rst = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.valid_out !== 1'b0) quiet = 1'b0;
    end
    check("abort_novld", 32'(quiet), 32'd1);
    check("abort_ready2", bus.ready, 1);

    @(negedge clk);
    bus.flag_ld = 1'b1; bus.flag_in = 4'b0101;
    bus.start = 1'b1; bus.sel = 5'h02; bus.a = 8'h01; bus.b = 8'h01;
    @(negedge clk);
    bus.start = 1'b0; bus.flag_ld = 1'b0;
    check("fld_out", bus.out, 8'h02);
    check("fld_ccr", bus.ccr, 4'b0101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-002 Parameter: CNT_W, default $clog2(WIDTH+1), width of the iteration counter.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: start  input  1  operation request; accepted only when ready=1.
REQ-006 Port: sel  input  5  opcode: 0x00 NOP, 0x01 PASS_B, 0x02 ADD, 0x03 SUB, 0x04 AND, 0x05 OR, 0x06 RLC, 0x07 RRC, 0x08 NOT, 0x09 NEG, 0x0A INC, 0x0B DEC, 0x0C SETC, 0x0D CLRC, 0x0E PASS_A, 0x0F INC_A, 0x10 MUL, 0x11 DIVU; others behave as NOP.
REQ-007 Port: a, b  input  WIDTH  operands, sampled on the acceptance edge only.
REQ-008 Port: flag_ld / flag_in  input  1 / 4  direct CCR load {V,C,N,Z}, used for interrupt-return restore.
REQ-009 Port: ready  output  1  high in IDLE, low while a multi-cycle operation runs.
REQ-010 Port: valid_out  output  1  one-cycle pulse when out/out_hi hold a new result.
REQ-011 Port: out, out_hi  output  WIDTH  result low half, and product high half or remainder.
REQ-012 Port: ccr  output  4  registered flags {V,C,N,Z}.

Function
REQ-013 States: IDLE and BUSY; start=1 in IDLE accepts the operation, and the ops 0x00-0x0F stay in IDLE.
REQ-014 Single-cycle ops: out is registered on the acceptance edge, valid_out=1 in the following cycle, and out_hi is unchanged.
REQ-015 MUL/DIVU: acceptance moves IDLE->BUSY, the counter loads WIDTH, and one shift-add or restore-subtract step runs per cycle; at counter 0 the result is registered, the state returns to IDLE, and valid_out pulses exactly WIDTH+1 cycles after acceptance.
REQ-016 start in BUSY is ignored, with no queuing, and a, b and sel changes in BUSY have no effect.
REQ-017 ADD/SUB use a WIDTH+1 sum: C=bit WIDTH (borrow on SUB), V=signed overflow, Z=(out==0), N=out[WIDTH-1], mask 1111.
REQ-018 AND, OR, NOT and NEG set Z and N only, with mask 0011.
REQ-019 INC/DEC set all four flags: INC gives V=(b==0x7F..F) and C=(b==all ones); DEC gives V=(b==0x80..0) and C=(b==0).
REQ-020 RLC gives out={b[W-2:0],ccr.C} with C=b[W-1]; RRC gives out={ccr.C,b[W-1:1]} with C=b[0]; the carry input is the registered ccr.C, not a port.
REQ-021 SETC/CLRC set or clear C only, and out is unchanged.
REQ-022 PASS_A, PASS_B and INC_A (out=a+1) leave the CCR unchanged, as does NOP, which also produces no valid_out.
REQ-023 MUL computes a full 2*WIDTH unsigned product {out_hi,out}: Z=(product==0), N=product[2W-1], C=V=(out_hi!=0).
REQ-024 DIVU gives out=quotient and out_hi=remainder, with Z/N taken from the quotient, C=0 and V=0.
REQ-025 DIVU with b==0 still takes WIDTH+1 cycles, returns out=all ones and out_hi=a, and sets V=1.
REQ-026 The CCR updates only the bits in the op mask, on the edge that registers the result.
REQ-027 If flag_ld=1 on the same edge as a result update, flag_in wins for all four bits.
REQ-028 flag_ld is accepted in any state.
REQ-029 Widths: all arithmetic wraps modulo 2^WIDTH, and flags are not sticky.

Reset
REQ-030 When rst=1: state=IDLE, ready=1, valid_out=0, out=0, out_hi=0, ccr=0000, counter=0, and internal operand registers are cleared.
REQ-031 rst asserted mid-BUSY aborts the operation, with no valid_out and no CCR update.
REQ-032 The first start is accepted on the first rising edge after rst deasserts.

Verification (WIDTH=8)
REQ-033 Assert rst -> ready=1, valid_out=0, out=0x00, out_hi=0x00, ccr=0000.
REQ-034 ADD a=0x7F b=0x01 -> next cycle out=0x80, valid_out=1, ccr=1010.
REQ-035 SETC, then RLC b=0x80 -> out=0x01, ccr.C=1; then RRC b=0x00 -> out=0x80, C=0.
REQ-036 MUL a=0x10 b=0x10 -> ready=0 for 8 cycles, with a start during BUSY ignored; valid_out at cycle 9, out=0x00, out_hi=0x01, ccr=1100.
REQ-037 DIVU 100/7 -> out=0x0E, out_hi=0x02, V=0; DIVU 7/0 -> out=0xFF, out_hi=0x07, V=1.
REQ-038 rst pulse at cycle 4 of MUL -> no valid_out, ccr=0000, ready=1; ADD with simultaneous flag_ld=1, flag_in=0101 -> ccr=0101.
